// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM tile controller and its row buffer.
// Holds the controller state encoding and an address-width helper.
// No logic of its own; imported by every file of the tile controller.
package cim_pkg;

    // Controller phases:
    // IDLE/LOAD accept row words, FIRE kicks the macro, COMPUTE waits,
    // DONE offers results downstream, DRAIN waits for the reader to finish.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FIRE    = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    // Address width for a table of 'depth' entries. A depth of 1 still gets
    // a one-bit address so that port declarations never collapse to zero width.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cim_row_buffer.sv
// Row-input register file feeding the crossbar macro; range-checks each write.
// Latency: an accepted write is visible on rows[] the cycle after the strobe.
// No backpressure: accept is combinational, wr_en AND addr inside the active rows.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears all rows)
//   wr_en             write request, already gated by the controller phase
//   addr, data        row address and word
//   accept            high when this cycle's write is stored (and should be counted)
//   rows[xbar_size]   buffered row words, held until overwritten or reset
module cim_row_buffer
    import cim_pkg::*;
#(
    parameter int xbar_size     = 256,
    parameter int datatype_size = 8,
    parameter int input_size    = 201
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [addr_width(xbar_size)-1:0] addr,
    input  logic [datatype_size-1:0]      data,
    output logic                          accept,
    output logic [datatype_size-1:0]      rows [xbar_size]
);

    localparam int AW = addr_width(xbar_size);

    // One extra bit so input_size == 2**AW still compares correctly.
    localparam logic [AW:0] LIMIT = (AW + 1)'(input_size);

    // Only rows below input_size are part of a load; anything above is
    // silently discarded and must not advance the word count.
    assign accept = wr_en && ({1'b0, addr} < LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < xbar_size; i++) begin
                rows[i] <= '0;
            end
        end else if (accept) begin
            rows[addr] <= data;
        end
    end

endmodule

// File: rtl/cim_tile_ctrl.sv
// Crossbar tile controller: loads row words, fires the macro, captures columns, hands off.
// Latency: last write -> o_fire 1 cycle; compute_cycles COMPUTE cycles; o_data/o_start next cycle.
// Backpressure: o_busy high from FIRE until downstream finishes (i_func_busy falls in DRAIN).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_we/i_addr/i_data  write strobe, row address, row word from the upstream func
//   o_busy              high while a load is not being accepted (upstream acknowledge)
//   o_row[]             buffered row words driven to the macro
//   o_fire              one-cycle pulse starting macro evaluation
//   i_col[]             macro column results
//   o_data[]            captured column results for the downstream func
//   o_start             start request to the downstream func
//   i_func_busy         downstream func busy
module cim_tile_ctrl
    import cim_pkg::*;
#(
    parameter int input_size           = 201,
    parameter int xbar_size            = 256,
    parameter int datatype_size        = 8,
    parameter int output_datatype_size = 16,
    parameter int compute_cycles       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_we,
    input  logic [addr_width(xbar_size)-1:0] i_addr,
    input  logic [datatype_size-1:0]        i_data,
    output logic                            o_busy,
    output logic [datatype_size-1:0]        o_row [xbar_size],
    output logic                            o_fire,
    input  logic [output_datatype_size-1:0] i_col [xbar_size],
    output logic [output_datatype_size-1:0] o_data [xbar_size],
    output logic                            o_start,
    input  logic                            i_func_busy
);

    localparam int WCW = $clog2(input_size + 1);
    localparam int CCW = $clog2(compute_cycles + 1);

    localparam logic [WCW-1:0] WC_LAST = WCW'(input_size - 1);
    localparam logic [WCW-1:0] WC_MAX  = WCW'(input_size);
    localparam logic [CCW-1:0] CC_LAST = CCW'(compute_cycles - 1);
    localparam logic [CCW-1:0] CC_MAX  = CCW'(compute_cycles);

    state_t         state;
    state_t         state_nxt;
    logic [WCW-1:0] write_cnt;
    logic [CCW-1:0] cyc_cnt;
    logic           wr_open;
    logic           accept;
    logic           capture;
    logic           cnt_clear;

    // Writes only reach the buffer while a load is open; writes in any
    // other phase (including the DRAIN->IDLE edge) are dropped here.
    cim_row_buffer #(
        .xbar_size    (xbar_size),
        .datatype_size(datatype_size),
        .input_size   (input_size)
    ) u_row_buffer (
        .clk   (clk),
        .rst   (rst),
        .wr_en (i_we && wr_open),
        .addr  (i_addr),
        .data  (i_data),
        .accept(accept),
        .rows  (o_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b1;
        o_fire    = 1'b0;
        o_start   = 1'b0;
        wr_open   = 1'b0;
        capture   = 1'b0;
        cnt_clear = 1'b0;
        case (state)
            IDLE, LOAD: begin
                o_busy  = 1'b0;
                wr_open = 1'b1;
                // The write that completes the row set goes straight to FIRE,
                // which also covers input_size == 1 from IDLE.
                if (accept) begin
                    state_nxt = (write_cnt == WC_LAST) ? FIRE : LOAD;
                end
            end
            FIRE: begin
                o_fire    = 1'b1;
                state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (cyc_cnt == CC_LAST) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_start = 1'b1;
                if (i_func_busy) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!i_func_busy) begin
                    cnt_clear = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Both counters saturate rather than wrap so a stray extra event can
    // never alias back onto a terminal compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_cnt <= '0;
            cyc_cnt   <= '0;
        end else begin
            if (cnt_clear) begin
                write_cnt <= '0;
            end else if (accept && (write_cnt != WC_MAX)) begin
                write_cnt <= write_cnt + 1'b1;
            end

            if (state == FIRE) begin
                cyc_cnt <= '0;
            end else if ((state == COMPUTE) && (cyc_cnt != CC_MAX)) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    // All columns are captured on the same edge; the result then holds
    // through DONE and DRAIN until the next load's capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < xbar_size; i++) begin
                o_data[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < xbar_size; i++) begin
                o_data[i] <= i_col[i];
            end
        end
    end

endmodule

// File: tb/tb_cim_tile_ctrl.sv
module tb_cim_tile_ctrl;

    localparam int XS = 8;
    localparam int IS = 4;
    localparam int CC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: input_size 4, compute_cycles 3
    logic        a_we;
    logic [2:0]  a_addr;
    logic [7:0]  a_data;
    logic        a_busy;
    logic [7:0]  a_row [XS];
    logic        a_fire;
    logic [15:0] a_col [XS];
    logic [15:0] a_odata [XS];
    logic        a_start;
    logic        a_fbusy;

    // DUT B: input_size 1, compute_cycles 1
    logic        b_we;
    logic [2:0]  b_addr;
    logic [7:0]  b_data;
    logic        b_busy;
    logic [7:0]  b_row [XS];
    logic        b_fire;
    logic [15:0] b_col [XS];
    logic [15:0] b_odata [XS];
    logic        b_start;
    logic        b_fbusy;

    cim_tile_ctrl #(.input_size(IS), .xbar_size(XS), .datatype_size(8),
                    .output_datatype_size(16), .compute_cycles(CC)) dut_a (
        .clk(clk), .rst(rst), .i_we(a_we), .i_addr(a_addr), .i_data(a_data),
        .o_busy(a_busy), .o_row(a_row), .o_fire(a_fire), .i_col(a_col),
        .o_data(a_odata), .o_start(a_start), .i_func_busy(a_fbusy));

    cim_tile_ctrl #(.input_size(1), .xbar_size(XS), .datatype_size(8),
                    .output_datatype_size(16), .compute_cycles(1)) dut_b (
        .clk(clk), .rst(rst), .i_we(b_we), .i_addr(b_addr), .i_data(b_data),
        .o_busy(b_busy), .o_row(b_row), .o_fire(b_fire), .i_col(b_col),
        .o_data(b_odata), .o_start(b_start), .i_func_busy(b_fbusy));

    int n_chk;
    int n_fail;

    // Reference model: expected buffer contents, expected captured results,
    // number of accepted words in the current load, and whether a load is open.
    logic [7:0]  m_row [XS];
    logic [15:0] m_data [XS];
    int          m_cnt;
    bit          m_open;
    logic [7:0]  bm_row [XS];
    logic [15:0] bm_data [XS];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < XS; i++) begin
            m_row[i] = '0; m_data[i] = '0; bm_row[i] = '0; bm_data[i] = '0;
        end
        m_cnt = 0;
        m_open = 1'b1;
    endtask

    task automatic a_check_rows(input string tag);
        for (int i = 0; i < XS; i++) begin
            n_chk++;
            if (a_row[i] !== m_row[i]) begin
                n_fail++;
                $display("FAIL %s row[%0d]: got %h expected %h", tag, i, a_row[i], m_row[i]);
            end
        end
    endtask

    // One write cycle on DUT A; the model decides whether it should count.
    task automatic a_write(input bit we, input logic [2:0] addr, input logic [7:0] d,
                           output bit closed);
        closed = 1'b0;
        a_we = we; a_addr = addr; a_data = d;
        cyc();
        a_we = 1'b0;
        if (we && m_open && (int'(addr) < IS)) begin
            m_row[addr] = d;
            m_cnt++;
            if (m_cnt == IS) begin
                m_open = 1'b0;
                closed = 1'b1;
            end
        end
        n_chk++;
        if (a_busy !== !m_open) begin
            n_fail++; $display("FAIL write_busy: got %b expected %b", a_busy, !m_open);
        end
        n_chk++;
        if (a_fire !== closed) begin
            n_fail++; $display("FAIL write_fire: got %b expected %b", a_fire, closed);
        end
        n_chk++;
        if (a_row[addr] !== m_row[addr]) begin
            n_fail++; $display("FAIL write_row[%0d]: got %h expected %h", addr, a_row[addr], m_row[addr]);
        end
    endtask

    task automatic a_load_seq(input string tag);
        bit closed;
        closed = 1'b0;
        for (int i = 0; i < IS; i++) begin
            a_write(1'b1, 3'(i), 8'($urandom), closed);
        end
        n_chk++;
        if (!closed) begin
            n_fail++; $display("FAIL %s_close: got 0 expected 1", tag);
        end
    endtask

    // Entered right after the FIRE sample. Runs COMPUTE (with dropped writes
    // and changing columns), DONE for done_cyc cycles (0 = reader already
    // busy), DRAIN for drain_cyc cycles, then back to IDLE.
    task automatic a_compute(input int done_cyc, input int drain_cyc, input bit we_exit);
        a_fbusy = (done_cyc == 0);
        for (int k = 1; k <= CC; k++) begin
            a_we = 1'b1; a_addr = 3'($urandom_range(IS - 1, 0)); a_data = 8'($urandom);
            cyc();
            n_chk++;
            if (a_start !== 1'b0 || a_fire !== 1'b0 || a_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL compute_%0d: got start=%b fire=%b busy=%b expected 0 0 1", k, a_start, a_fire, a_busy);
            end
            for (int c = 0; c < XS; c++) begin
                a_col[c] = 16'($urandom);
                m_data[c] = a_col[c];
            end
        end
        a_we = 1'b0;
        cyc();
        n_chk++;
        if (a_start !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL done_entry: got start=%b busy=%b expected 1 1", a_start, a_busy);
        end
        for (int c = 0; c < XS; c++) begin
            n_chk++;
            if (a_odata[c] !== m_data[c]) begin
                n_fail++; $display("FAIL capture[%0d]: got %h expected %h", c, a_odata[c], m_data[c]);
            end
            a_col[c] = ~m_data[c];
        end
        for (int d = 1; d < done_cyc; d++) begin
            cyc();
            n_chk++;
            if (a_start !== 1'b1 || a_busy !== 1'b1 || a_odata[d % XS] !== m_data[d % XS]) begin
                n_fail++; $display("FAIL done_hold_%0d: got start=%b busy=%b expected 1 1", d, a_start, a_busy);
            end
        end
        a_fbusy = 1'b1;
        cyc();
        n_chk++;
        if (a_start !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL drain_entry: got start=%b busy=%b expected 0 1", a_start, a_busy);
        end
        for (int d = 1; d < drain_cyc; d++) begin
            a_we = 1'($urandom); a_addr = 3'($urandom); a_data = 8'($urandom);
            cyc();
            n_chk++;
            if (a_start !== 1'b0 || a_busy !== 1'b1) begin
                n_fail++; $display("FAIL drain_hold_%0d: got start=%b busy=%b expected 0 1", d, a_start, a_busy);
            end
        end
        // A write on the DRAIN->IDLE edge must be dropped.
        a_we = we_exit; a_addr = 3'd0; a_data = ~m_row[0];
        a_fbusy = 1'b0;
        cyc();
        a_we = 1'b0;
        n_chk++;
        if (a_busy !== 1'b0 || a_start !== 1'b0) begin
            n_fail++; $display("FAIL idle_return: got busy=%b start=%b expected 0 0", a_busy, a_start);
        end
        n_chk++;
        if (a_row[0] !== m_row[0]) begin
            n_fail++; $display("FAIL exit_write_row0: got %h expected %h", a_row[0], m_row[0]);
        end
        for (int c = 0; c < XS; c++) begin
            n_chk++;
            if (a_odata[c] !== m_data[c]) begin
                n_fail++; $display("FAIL data_hold[%0d]: got %h expected %h", c, a_odata[c], m_data[c]);
            end
        end
        m_cnt = 0;
        m_open = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_we = 0; a_addr = 0; a_data = 0; a_fbusy = 0;
        b_we = 0; b_addr = 0; b_data = 0; b_fbusy = 0;
        for (int c = 0; c < XS; c++) begin a_col[c] = '0; b_col[c] = '0; end
        model_reset();
        #1;
        n_chk++;
        if (a_busy !== 1'b0 || a_fire !== 1'b0 || a_start !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got busy=%b fire=%b start=%b expected 0 0 0", a_busy, a_fire, a_start);
        end
        for (int c = 0; c < XS; c++) begin
            n_chk++;
            if (a_odata[c] !== 16'h0 || a_row[c] !== 8'h0) begin
                n_fail++; $display("FAIL reset_arrays[%0d]: got data=%h row=%h expected 0 0", c, a_odata[c], a_row[c]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_load();
        bit closed;
        closed = 1'b0;
        for (int i = 0; i < IS; i++) begin
            a_write(1'b1, 3'(i), 8'(8'h11 * (i + 1)), closed);
        end
        n_chk++;
        if (!closed || a_row[3] !== 8'h44) begin
            n_fail++; $display("FAIL full_load: got closed=%b row3=%h expected 1 44", closed, a_row[3]);
        end
        a_check_rows("full_load");
        a_compute(5, 10, 1'b0);
    endtask

    task automatic test_out_of_range();
        bit closed;
        a_write(1'b1, 3'd5, 8'hA5, closed);
        n_chk++;
        if (closed || a_row[5] !== 8'h00) begin
            n_fail++; $display("FAIL oor_drop: got closed=%b row5=%h expected 0 00", closed, a_row[5]);
        end
        a_load_seq("oor");
        a_compute(2, 3, 1'b0);
        a_check_rows("oor_after_compute");
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 3; it++) begin
            bit closed;
            closed = 1'b0;
            for (int n = 0; n < 200 && !closed; n++) begin
                a_write(($urandom % 4) != 0, 3'($urandom), 8'($urandom), closed);
            end
            n_chk++;
            if (!closed) begin
                n_fail++; $display("FAIL b2b_timeout_%0d: got no fire expected fire within 200 cycles", it);
            end else begin
                a_check_rows("b2b");
                a_compute(int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), 1'b1);
            end
        end
    endtask

    task automatic test_busy_early();
        a_load_seq("early");
        a_compute(0, 2, 1'b0);
    endtask

    task automatic test_single();
        logic [7:0] d;
        b_fbusy = 1'b0;
        b_we = 1'b1; b_addr = 3'd3; b_data = 8'h5A;
        cyc();
        n_chk++;
        if (b_busy !== 1'b0 || b_fire !== 1'b0) begin
            n_fail++; $display("FAIL single_oor: got busy=%b fire=%b expected 0 0", b_busy, b_fire);
        end
        d = 8'($urandom);
        b_addr = 3'd0; b_data = d;
        cyc();
        b_we = 1'b0;
        bm_row[0] = d;
        n_chk++;
        if (b_fire !== 1'b1 || b_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_fire: got fire=%b busy=%b expected 1 1", b_fire, b_busy);
        end
        for (int c = 0; c < XS; c++) begin
            b_col[c] = 16'($urandom); bm_data[c] = b_col[c];
        end
        cyc();
        n_chk++;
        if (b_fire !== 1'b0 || b_start !== 1'b0) begin
            n_fail++; $display("FAIL single_compute: got fire=%b start=%b expected 0 0", b_fire, b_start);
        end
        cyc();
        n_chk++;
        if (b_start !== 1'b1) begin
            n_fail++; $display("FAIL single_start: got %b expected 1", b_start);
        end
        for (int c = 0; c < XS; c++) begin
            n_chk++;
            if (b_odata[c] !== bm_data[c] || b_row[c] !== bm_row[c]) begin
                n_fail++; $display("FAIL single_data[%0d]: got %h/%h expected %h/%h", c, b_odata[c], b_row[c], bm_data[c], bm_row[c]);
            end
        end
        b_fbusy = 1'b1;
        cyc();
        n_chk++;
        if (b_start !== 1'b0 || b_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_drain: got start=%b busy=%b expected 0 1", b_start, b_busy);
        end
        b_fbusy = 1'b0;
        cyc();
        n_chk++;
        if (b_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got busy=%b expected 0", b_busy);
        end
    endtask

    task automatic test_async_reset();
        a_load_seq("pre_reset");
        cyc();
        n_chk++;
        if (a_busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_busy: got %b expected 1", a_busy);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (a_busy !== 1'b0 || a_fire !== 1'b0 || a_start !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_ctrl: got busy=%b fire=%b start=%b expected 0 0 0", a_busy, a_fire, a_start);
        end
        for (int c = 0; c < XS; c++) begin
            n_chk++;
            if (a_odata[c] !== 16'h0 || b_odata[c] !== 16'h0 || b_row[c] !== 8'h0) begin
                n_fail++; $display("FAIL async_reset_data[%0d]: got %h expected 0", c, a_odata[c]);
            end
        end
        a_check_rows("async_reset");
        @(negedge clk);
        rst = 1'b0;
        a_load_seq("post_reset");
        a_check_rows("post_reset");
        a_compute(1, 1, 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_full_load();
        test_out_of_range();
        test_back_to_back();
        test_busy_early();
        test_single();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/cim_tile_ctrl.md
Name: cim_tile_ctrl

Overview:
Crossbar-side responder for the functional-unit load protocol (we/addr/data with busy handshake).
- Accepts input_size words into a row-input buffer.
- Fires the crossbar macro and waits a fixed compute latency, then captures the column outputs.
- Presents the captured outputs to the next layer's functional unit and holds them until that unit finishes reading.
- Sits between one layer's func block and the next layer's func block.

Parameters:
input_size, 201, number of row words per load (1..xbar_size)
xbar_size, 256, crossbar rows/columns; address space of i_addr
datatype_size, 8, input word width
output_datatype_size, 16, column result width
compute_cycles, 4, macro latency in clk cycles from fire to capture (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
i_we  in  1  write strobe from upstream func
i_addr  in  $clog2(xbar_size)  row address of write
i_data  in  datatype_size  row word
o_busy  out  1  to upstream func (its cim_busy input); high = not accepting a new load
o_row [xbar_size]  out  datatype_size each  buffered row inputs driven to the macro
o_fire  out  1  one-cycle pulse starting macro evaluation
i_col [xbar_size]  in  output_datatype_size each  macro column results
o_data [xbar_size]  out  output_datatype_size each  captured results to the downstream func
o_start  out  1  start request to the downstream func
i_func_busy  in  1  downstream func busy

Behaviour:
Reset (async, any state): state=IDLE; write_cnt=0; cyc_cnt=0; o_row, o_data all 0; o_busy=0; o_fire=0; o_start=0.

States and transitions:
- IDLE: o_busy=0. First accepted write moves to LOAD.
- LOAD: o_busy=0. Writes are accepted.
  - The accepted write that makes write_cnt==input_size moves to FIRE.
  - If input_size==1, the first write in IDLE goes directly to FIRE.
- FIRE: o_busy=1; o_fire=1 for exactly this cycle; cyc_cnt<=0; next state COMPUTE.
- COMPUTE: o_busy=1; cyc_cnt increments each cycle.
  - When cyc_cnt==compute_cycles-1: o_data<=i_col (all columns, same edge); next state DONE.
- DONE: o_busy=1; o_start=1.
  - When i_func_busy==1: next state DRAIN; o_start drops on that edge.
- DRAIN: o_busy=1; o_start=0; o_data held.
  - When i_func_busy==0: write_cnt<=0; next state IDLE.

Write acceptance:
- A write is accepted only when i_we=1, state is IDLE or LOAD, and i_addr<input_size.
- An accepted write does o_row[i_addr]<=i_data and write_cnt<=write_cnt+1.
- Writes with i_addr>=input_size are dropped and not counted.
- Writes in FIRE/COMPUTE/DONE/DRAIN are dropped silently.
- A duplicate address overwrites the word and still counts.

Timing and latency:
- Last write edge to o_fire high: 1 cycle.
- o_fire to o_data valid: compute_cycles cycles.
- o_data valid in the same cycle o_start rises.
- o_busy rises on the edge after the last accepted write. This is the acknowledge the upstream func waits for before returning to its reset state.

Data retention:
- o_row is never cleared except by reset. The next load overwrites it.
- o_data is stable from DONE until the next capture.

Simultaneous events:
- i_func_busy already high on DONE entry: DONE lasts exactly one cycle, with o_start=1 for that cycle.
- i_we during the DRAIN→IDLE edge: dropped. Acceptance resumes in the cycle after state==IDLE.

Widths: write_cnt is $clog2(input_size+1) bits; cyc_cnt is $clog2(compute_cycles+1) bits. Both saturate at their terminal value; neither wraps.

Decomposition:
- Shared package cim_pkg: state enum (IDLE, LOAD, FIRE, COMPUTE, DONE, DRAIN) and a clog2-based address-width constant helper.
- One natural sub-module, cim_row_buffer: addressed register file with write enable and range check, xbar_size×datatype_size, async reset. The FSM and counters stay in the top level.

Test Plan:
1. Reset: assert rst mid-COMPUTE (async, between edges) -> o_busy, o_fire, o_start fall immediately; o_data all 0; state IDLE.
2. Full load: input_size=4, compute_cycles=3; write addr 0..3 with data 0x11,0x22,0x33,0x44 -> o_busy=1 the next cycle; o_fire pulses once; o_row[0..3] match; o_data==i_col exactly 3 cycles after o_fire; o_start=1.
3. Out-of-range and late writes: input_size=4; write addr 5, then addr 0..3; then write during COMPUTE -> addr 5 not stored and not counted; FIRE follows addr 3; the COMPUTE-time write leaves o_row unchanged.
4. Downstream handshake: in DONE hold i_func_busy=0 for 5 cycles, then 1 for 10 cycles, then 0 -> o_start high 5 cycles then low; o_busy stays 1 through DRAIN; IDLE one cycle after i_func_busy falls; o_data stable throughout.
5. Back-to-back loads: second load with new data immediately after DRAIN exits -> second o_fire; o_data updated to the new i_col values; write_cnt restarted from 0.
6. Edge cases: input_size=1 -> a single write goes IDLE→FIRE. Separately, i_func_busy already high when DONE is entered -> o_start is a one-cycle pulse.
